// File: rtl/hbm_rd_data_demux.sv
// hbm_rd_data_demux: steers HBM R-channel beats by RID into per-class FWFT FIFOs and counts beats.
// Define HBM_RD_ERR_CHECK_EN to compile in sticky burst-framing / response / ID error checking.
module hbm_rd_data_demux #(
  parameter int                  DATA_WIDTH  = 256,
  parameter int                  ID_WIDTH    = 6,
  parameter logic [ID_WIDTH-1:0] B_TAG       = 6'd0,
  parameter logic [ID_WIDTH-1:0] A_TAG       = 6'd1,
  parameter int                  FIFO_DEPTH  = 16,
  parameter int                  BURST_BEATS = 4
) (
  input  logic                  hbm_clk,
  input  logic                  hbm_aresetn,
  input  logic                  clear,
  input  logic                  m_axi_RVALID,
  output logic                  m_axi_RREADY,
  input  logic [DATA_WIDTH-1:0] m_axi_RDATA,
  input  logic [ID_WIDTH-1:0]   m_axi_RID,
  input  logic [1:0]            m_axi_RRESP,
  input  logic                  m_axi_RLAST,
  output logic                  b_valid,
  input  logic                  b_ready,
  output logic [DATA_WIDTH-1:0] b_data,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic [DATA_WIDTH-1:0] a_data,
  output logic [31:0]           a_beat_cnt,
  output logic [31:0]           b_beat_cnt,
  output logic                  err,
  output logic [2:0]            err_code
);

  localparam int              PW       = $clog2(FIFO_DEPTH);
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   FULL_LVL = CW'(FIFO_DEPTH);
  localparam logic [1:0]      LAST_IDX = 2'(BURST_BEATS - 1);

  logic                  running_r;
  logic [DATA_WIDTH-1:0] a_mem_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] b_mem_r [FIFO_DEPTH];
  logic [PW-1:0]         a_wr_ptr_r, a_rd_ptr_r, b_wr_ptr_r, b_rd_ptr_r;
  logic [CW-1:0]         a_count_r, b_count_r, a_count_nxt_s, b_count_nxt_s;
  logic [31:0]           a_beat_cnt_r, b_beat_cnt_r;
  logic [1:0]            a_idx_r, b_idx_r;
  logic                  accept_s, rid_a_s, rid_b_s;
  logic                  a_push_s, b_push_s, a_pop_s, b_pop_s;

  // Ready is held low until the first clock after reset release.
  assign m_axi_RREADY = running_r & ~clear & (a_count_r < FULL_LVL) & (b_count_r < FULL_LVL);
  assign accept_s     = m_axi_RVALID & m_axi_RREADY;
  assign rid_a_s      = (m_axi_RID == A_TAG);
  assign rid_b_s      = (m_axi_RID == B_TAG) & ~rid_a_s;
  assign a_push_s     = accept_s & rid_a_s;
  assign b_push_s     = accept_s & rid_b_s;
  assign a_valid      = (a_count_r != {CW{1'b0}});
  assign b_valid      = (b_count_r != {CW{1'b0}});
  assign a_pop_s      = a_valid & a_ready;
  assign b_pop_s      = b_valid & b_ready;
  assign a_data       = a_mem_r[a_rd_ptr_r];
  assign b_data       = b_mem_r[b_rd_ptr_r];
  assign a_beat_cnt   = a_beat_cnt_r;
  assign b_beat_cnt   = b_beat_cnt_r;

  // Next occupancy of each FIFO from its push/pop pair.
  always_comb begin
    a_count_nxt_s = a_count_r;
    b_count_nxt_s = b_count_r;
    case ({a_push_s, a_pop_s})
      2'b10:   a_count_nxt_s = a_count_r + CW'(1);
      2'b01:   a_count_nxt_s = a_count_r - CW'(1);
      default: a_count_nxt_s = a_count_r;
    endcase
    case ({b_push_s, b_pop_s})
      2'b10:   b_count_nxt_s = b_count_r + CW'(1);
      2'b01:   b_count_nxt_s = b_count_r - CW'(1);
      default: b_count_nxt_s = b_count_r;
    endcase
  end

  // FIFO storage; contents are don't-care until pointed at by a valid count.
  always_ff @(posedge hbm_clk) begin
    if (a_push_s) a_mem_r[a_wr_ptr_r] <= m_axi_RDATA;
    if (b_push_s) b_mem_r[b_wr_ptr_r] <= m_axi_RDATA;
  end

  // Pointers, occupancy, beat counters and per-class burst indices.
  always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
    if (!hbm_aresetn) begin
      running_r    <= 1'b0;
      a_wr_ptr_r   <= {PW{1'b0}};
      a_rd_ptr_r   <= {PW{1'b0}};
      b_wr_ptr_r   <= {PW{1'b0}};
      b_rd_ptr_r   <= {PW{1'b0}};
      a_count_r    <= {CW{1'b0}};
      b_count_r    <= {CW{1'b0}};
      a_beat_cnt_r <= 32'd0;
      b_beat_cnt_r <= 32'd0;
      a_idx_r      <= 2'd0;
      b_idx_r      <= 2'd0;
    end else if (clear) begin
      running_r    <= 1'b1;
      a_wr_ptr_r   <= {PW{1'b0}};
      a_rd_ptr_r   <= {PW{1'b0}};
      b_wr_ptr_r   <= {PW{1'b0}};
      b_rd_ptr_r   <= {PW{1'b0}};
      a_count_r    <= {CW{1'b0}};
      b_count_r    <= {CW{1'b0}};
      a_beat_cnt_r <= 32'd0;
      b_beat_cnt_r <= 32'd0;
      a_idx_r      <= 2'd0;
      b_idx_r      <= 2'd0;
    end else begin
      running_r <= 1'b1;
      a_count_r <= a_count_nxt_s;
      b_count_r <= b_count_nxt_s;
      if (a_push_s) begin
        a_wr_ptr_r   <= a_wr_ptr_r + PW'(1);
        a_beat_cnt_r <= a_beat_cnt_r + 32'd1;
        a_idx_r      <= (a_idx_r == LAST_IDX) ? 2'd0 : a_idx_r + 2'd1;
      end
      if (b_push_s) begin
        b_wr_ptr_r   <= b_wr_ptr_r + PW'(1);
        b_beat_cnt_r <= b_beat_cnt_r + 32'd1;
        b_idx_r      <= (b_idx_r == LAST_IDX) ? 2'd0 : b_idx_r + 2'd1;
      end
      if (a_pop_s) a_rd_ptr_r <= a_rd_ptr_r + PW'(1);
      if (b_pop_s) b_rd_ptr_r <= b_rd_ptr_r + PW'(1);
    end
  end

`ifdef HBM_RD_ERR_CHECK_EN
  logic [2:0] err_code_r;
  logic [2:0] err_hit_s;
  logic       idx_last_s;

  // Error causes seen on the beat being accepted this cycle.
  always_comb begin
    err_hit_s  = 3'b000;
    idx_last_s = 1'b0;
    if (rid_a_s) begin
      idx_last_s = (a_idx_r == LAST_IDX);
    end else if (rid_b_s) begin
      idx_last_s = (b_idx_r == LAST_IDX);
    end else begin
      idx_last_s = 1'b0;
    end
    if (accept_s) begin
      err_hit_s[0] = (m_axi_RRESP != 2'b00);
      err_hit_s[1] = (rid_a_s | rid_b_s) & (m_axi_RLAST != idx_last_s);
      err_hit_s[2] = ~(rid_a_s | rid_b_s);
    end else begin
      err_hit_s = 3'b000;
    end
  end

  // Sticky error causes, cleared only by reset or clear.
  always_ff @(posedge hbm_clk or negedge hbm_aresetn) begin
    if (!hbm_aresetn) begin
      err_code_r <= 3'b000;
    end else if (clear) begin
      err_code_r <= 3'b000;
    end else begin
      err_code_r <= err_code_r | err_hit_s;
    end
  end

  assign err_code = err_code_r;
  assign err      = |err_code_r;
`else
  logic unused_err_inputs_s;
  assign unused_err_inputs_s = ^{m_axi_RRESP, m_axi_RLAST};
  assign err_code = 3'b000;
  assign err      = 1'b0;
`endif

endmodule

// File: doc/hbm_rd_data_demux.md
# hbm_rd_data_demux

Read-data return stage for one HBM pseudo-channel; it sits directly downstream of the SGD read-address generator. It accepts AXI R-channel beats and steers them by RID tag: model/label (B) beats go to the B stream and sample-feature (A) beats go to the A stream. Each stream is buffered in its own FIFO, and the block counts beats per class. Optionally, it checks burst framing and response codes.

## Interface
Parameters:
- DATA_WIDTH, 256: R-channel and stream data width.
- ID_WIDTH, 6: RID width.
- B_TAG, 6'd0: RID value that marks B (model/label) beats; equals `MEM_RD_B_TAG.
- A_TAG, 6'd1: RID value that marks A (sample) beats; equals `MEM_RD_A_TAG.
- FIFO_DEPTH, 16: entries per stream FIFO; must be a power of 2 and at least 4.
- BURST_BEATS, 4: beats per read burst (ARLEN+1).

Ports:
- hbm_clk, in, 1: sole clock.
- hbm_aresetn, in, 1: reset, asynchronous, active-low.
- clear, in, 1: synchronous job restart; flushes both FIFOs, counters and error state.
- m_axi_RVALID, in, 1: read data valid.
- m_axi_RREADY, out, 1: read data ready.
- m_axi_RDATA, in, DATA_WIDTH: read data.
- m_axi_RID, in, ID_WIDTH: read ID.
- m_axi_RRESP, in, 2: read response.
- m_axi_RLAST, in, 1: last beat of burst.
- b_valid, out, 1: B stream valid.
- b_ready, in, 1: B stream ready.
- b_data, out, DATA_WIDTH: B stream data.
- a_valid, out, 1: A stream valid.
- a_ready, in, 1: A stream ready.
- a_data, out, DATA_WIDTH: A stream data.
- a_beat_cnt, out, 32: accepted A beats since the last clear.
- b_beat_cnt, out, 32: accepted B beats since the last clear.
- err, out, 1: sticky error flag.
- err_code, out, 3: sticky error causes.

## Operation
Handshake and steering:
- A beat is accepted when m_axi_RVALID and m_axi_RREADY are both high.
- m_axi_RREADY = !clear & (a_count < FIFO_DEPTH) & (b_count < FIFO_DEPTH). It is combinational from registered occupancy and never depends on RVALID.
- When RID == A_TAG, RDATA is pushed into the A FIFO and a_beat_cnt increments.
- When RID == B_TAG, RDATA is pushed into the B FIFO and b_beat_cnt increments.
- Any other RID is accepted and dropped. It is never pushed into either FIFO.

FIFOs:
- Both FIFOs are first-word-fall-through. x_valid = (x_count != 0) and x_data is the head entry.
- A pop occurs on x_valid & x_ready.
- A push and a pop in the same cycle leave x_count unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.

Burst tracking:
- Each class keeps its own 2-bit beat index, because A and B bursts may interleave.
- The index increments on each accepted beat of that class and resets to 0 after beat BURST_BEATS-1.

Counters and clear:
- Beat counters are 32-bit and wrap from 0xFFFF_FFFF to 0.
- clear has priority over every other event. In its cycle it zeroes counts, pointers, beat counters, beat indices, err and err_code. RREADY is low during that cycle, so no beat is lost.

## Timing
- Reset values: m_axi_RREADY=0 while hbm_aresetn is low, then 1 after release. a_valid=0, b_valid=0, a_beat_cnt=0, b_beat_cnt=0, err=0, err_code=0. Data outputs are don't-care.
- Latency: a beat accepted at cycle t into an empty FIFO gives x_valid=1 with that data at cycle t+1.
- Beat counters update at t+1.
- Throughput: one beat per cycle sustained whenever both FIFOs are not full and downstream pops.
- Full FIFO: RREADY drops in the cycle the count reaches FIFO_DEPTH. This applies even if the pending beat targets the other stream (head-of-line blocking is accepted).
- RREADY returns high in the cycle after the pop that frees the slot.
- Reset mid-burst: all state clears immediately. Partially received bursts are lost, and the upstream issuer must restart.

## Configuration
Macro HBM_RD_ERR_CHECK_EN, when defined, compiles in error checking. Each cause sets err=1 and its err_code bit; both stay set until clear or reset. Flags update on the accepted beat and are visible at t+1.
- err_code[0]: RRESP != 0.
- err_code[1]: RLAST disagrees with (beat index == BURST_BEATS-1) for the beat's class.
- err_code[2]: RID is neither A_TAG nor B_TAG.

Without the macro, err and err_code are tied to 0 and the checking logic is absent. Steering, dropping of unknown IDs and counters behave identically in both builds.

## Test plan
- Reset, then one 4-beat burst with RID=1 and data 0x11..0x14, a_ready=1 -> a_valid beats 0x11..0x14 in order, starting 1 cycle after the first accept; a_beat_cnt=4; b_valid stays 0.
- Interleave B and A beats (RID 0,1,0,1 ... two bursts each) -> each stream keeps its own order; a_beat_cnt=8; b_beat_cnt=8; err=0.
- Hold a_ready=0 and send 20 A beats with FIFO_DEPTH=16 -> RREADY low after 16 accepts; releasing a_ready drains all 20 in order with no loss or duplication.
- Send RID=5 for one burst -> nothing is pushed and both counters stay unchanged. With HBM_RD_ERR_CHECK_EN, err=1 and err_code=3'b100.
- Send a burst with RLAST on beat 2 and RRESP=2 on beat 0 (macro on) -> err_code=3'b011; pulse clear -> err=0 and all counters 0.
- Assert hbm_aresetn low mid-burst with both FIFOs at 5 entries -> a_valid=0, b_valid=0 and RREADY=0 immediately; after release a fresh burst is delivered correctly.
